// File: rtl/config_regmap_dbuf.sv
// Double-buffered configuration register map: shadow bank for writes, active bank for outputs, settle window after commit.
// Optional active-bank parity scrubbing is enabled by defining REGMAP_PARITY_EN.
module config_regmap_dbuf #(
    parameter int unsigned                     NUMREGS     = 32,
    parameter int unsigned                     REGWIDTH    = 8,
    parameter int unsigned                     ADDRWIDTH   = 5,
    parameter logic [NUMREGS*REGWIDTH-1:0]     DEFAULTS    = '0,
    parameter int unsigned                     LOCK_ADDR   = 31,
    parameter int unsigned                     COMMIT_HOLD = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDRWIDTH-1:0]          wr_addr,
    input  logic [REGWIDTH-1:0]           wr_data,
    output logic                          wr_resp,
    output logic                          wr_err,
    input  logic                          rd_valid,
    output logic                          rd_ready,
    input  logic [ADDRWIDTH-1:0]          rd_addr,
    input  logic                          rd_src,
    output logic                          rd_resp,
    output logic [REGWIDTH-1:0]           rd_data,
    output logic                          rd_err,
    input  logic                          commit,
    input  logic                          revert,
    output logic                          busy,
    output logic                          commit_done,
    output logic                          pending,
    output logic [NUMREGS*REGWIDTH-1:0]   config_bits,
    output logic                          parity_err
);

    localparam int unsigned IDX_W = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;
    localparam int unsigned CNT_W = (COMMIT_HOLD > 1) ? $clog2(COMMIT_HOLD) : 1;

    typedef enum logic {S_IDLE, S_SETTLE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [REGWIDTH-1:0]  r_shadow [NUMREGS];
    logic [REGWIDTH-1:0]  r_active [NUMREGS];

    logic             w_idle;
    logic             w_commit;
    logic             w_revert;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_wr_oob;
    logic             w_wr_err;
    logic             w_rd_oob;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;

    assign w_idle   = (r_state == S_IDLE);
    assign w_commit = w_idle & commit;
    assign w_revert = w_idle & ~commit & revert;
    assign w_wr_acc = wr_valid & wr_ready;
    assign w_rd_acc = rd_valid & rd_ready;
    assign w_wr_oob = 32'(wr_addr) >= NUMREGS;
    assign w_rd_oob = 32'(rd_addr) >= NUMREGS;
    assign w_wr_idx = IDX_W'(wr_addr);
    assign w_rd_idx = IDX_W'(rd_addr);
    // A committed lock bit rejects everything except the lock register itself.
    assign w_wr_err = w_wr_oob | (r_active[IDX_W'(LOCK_ADDR)][0] & (32'(wr_addr) != LOCK_ADDR));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (commit && (COMMIT_HOLD != 0)) w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_cnt == '0) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ready = 1'b0;
        rd_ready = 1'b0;
        busy     = 1'b0;
        case (r_state)
            S_IDLE: begin
                wr_ready = ~commit & ~revert;
                rd_ready = ~commit & ~revert & ~wr_valid;
            end
            S_SETTLE: busy = 1'b1;
            default: ;
        endcase
    end

    // Settle counter and end-of-window pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            commit_done <= 1'b0;
        end else begin
            commit_done <= (w_commit && (COMMIT_HOLD == 0)) || ((r_state == S_SETTLE) && (r_cnt == '0));
            if (w_commit)                                r_cnt <= CNT_W'(COMMIT_HOLD - 1);
            else if (r_state == S_SETTLE && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

`ifdef REGMAP_PARITY_EN
    logic             r_par [NUMREGS];
    logic [IDX_W-1:0] r_scrub;
    logic             w_scrub_fix;

    assign w_scrub_fix = (^r_active[r_scrub]) != r_par[r_scrub];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUMREGS; i++) r_par[i] <= ^DEFAULTS[i*REGWIDTH +: REGWIDTH];
            r_scrub    <= '0;
            parity_err <= 1'b0;
        end else begin
            r_scrub <= (r_scrub == IDX_W'(NUMREGS - 1)) ? '0 : r_scrub + IDX_W'(1);
            if (w_commit) begin
                for (int unsigned i = 0; i < NUMREGS; i++) r_par[i] <= ^r_shadow[i];
                parity_err <= 1'b0;
            end else if (w_scrub_fix) begin
                r_par[r_scrub] <= ^DEFAULTS[32'(r_scrub)*REGWIDTH +: REGWIDTH];
                parity_err     <= 1'b1;
            end
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Banks: commit overrides a scrub restore on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUMREGS; i++) begin
                r_shadow[i] <= DEFAULTS[i*REGWIDTH +: REGWIDTH];
                r_active[i] <= DEFAULTS[i*REGWIDTH +: REGWIDTH];
            end
        end else begin
            if (w_commit) begin
                for (int unsigned i = 0; i < NUMREGS; i++) r_active[i] <= r_shadow[i];
            end
`ifdef REGMAP_PARITY_EN
            else if (w_scrub_fix) begin
                r_active[r_scrub] <= DEFAULTS[32'(r_scrub)*REGWIDTH +: REGWIDTH];
            end
`endif
            if (w_revert) begin
                for (int unsigned i = 0; i < NUMREGS; i++) r_shadow[i] <= r_active[i];
            end else if (w_wr_acc && !w_wr_err) begin
                r_shadow[w_wr_idx] <= wr_data;
            end
        end
    end

    // Responses and the pending flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_resp <= 1'b0;
            wr_err  <= 1'b0;
            rd_resp <= 1'b0;
            rd_err  <= 1'b0;
            rd_data <= '0;
            pending <= 1'b0;
        end else begin
            wr_resp <= w_wr_acc;
            wr_err  <= w_wr_acc & w_wr_err;
            rd_resp <= w_rd_acc;
            rd_err  <= w_rd_acc & w_rd_oob;
            if (w_rd_acc) begin
                if (w_rd_oob)    rd_data <= '0;
                else if (rd_src) rd_data <= r_active[w_rd_idx];
                else             rd_data <= r_shadow[w_rd_idx];
            end
            if (w_commit || w_revert)        pending <= 1'b0;
            else if (w_wr_acc && !w_wr_err)  pending <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUMREGS; g++) begin : g_cfg
        assign config_bits[g*REGWIDTH +: REGWIDTH] = r_active[g];
    end

endmodule

// File: tb/tb_config_regmap_dbuf.sv
// Randomized scoreboard bench for config_regmap_dbuf against a bank-level reference model.
module tb_config_regmap_dbuf;

    localparam int unsigned NR = 32;
    localparam int unsigned RW = 8;
    localparam int unsigned AW = 6;
    localparam int unsigned LK = 31;
    localparam int unsigned H  = 16;

    function automatic logic [NR*RW-1:0] mkdef();
        logic [NR*RW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*RW +: RW] = 8'(i*37 + 11);
        v[LK*RW] = 1'b0;
        return v;
    endfunction
    localparam logic [NR*RW-1:0] DEF = mkdef();

    logic clk = 1'b0, reset = 1'b1;
    logic wr_valid = 0, wr_ready, wr_resp, wr_err;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [RW-1:0] wr_data = '0, rd_data;
    logic rd_valid = 0, rd_ready, rd_src = 0, rd_resp, rd_err;
    logic commit = 0, revert = 0, busy, commit_done, pending, parity_err;
    logic [NR*RW-1:0] config_bits;

    config_regmap_dbuf #(.NUMREGS(NR), .REGWIDTH(RW), .ADDRWIDTH(AW), .DEFAULTS(DEF),
                         .LOCK_ADDR(LK), .COMMIT_HOLD(H)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_resp(wr_resp), .wr_err(wr_err),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_src(rd_src),
        .rd_resp(rd_resp), .rd_data(rd_data), .rd_err(rd_err),
        .commit(commit), .revert(revert), .busy(busy), .commit_done(commit_done),
        .pending(pending), .config_bits(config_bits), .parity_err(parity_err));

    always #5 clk = ~clk;

    typedef struct { int c; bit err; } wexp_t;
    typedef struct { int c; logic [RW-1:0] d; bit err; } rexp_t;
    wexp_t wq[$];
    rexp_t rq[$];
    int    cq[$];

    logic [RW-1:0] m_sh [NR];
    logic [RW-1:0] m_ac [NR];
    bit m_pend = 0, m_perr = 0, inject = 0, mon_en = 0;
    int m_free = 0, cyc = 0, checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [NR*RW-1:0] got, input logic [NR*RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    function automatic logic [NR*RW-1:0] pack_ac();
        logic [NR*RW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*RW +: RW] = m_ac[i];
        return v;
    endfunction

    // One cycle of stimulus: drive at negedge, check readys, advance the model for the coming edge.
    task automatic step(input bit c, input bit r, input bit wv, input logic [AW-1:0] wa,
                        input logic [RW-1:0] wd, input bit rv, input logic [AW-1:0] ra,
                        input bit rs, output bit wacc, output bit racc);
        int  k;
        bit  idle, err;
        logic [RW-1:0] d;
        @(negedge clk);
        commit = c; revert = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra; rd_src = rs;
        #1;
        k = cyc;
        idle = (k >= m_free);
        wacc = 0; racc = 0;
        chk("wr_ready", NR*RW'(wr_ready), NR*RW'(idle & !c & !r));
        chk("rd_ready", NR*RW'(rd_ready), NR*RW'(idle & !c & !r & !wv));
        if (idle && c) begin
            for (int i = 0; i < NR; i++) m_ac[i] = m_sh[i];
            m_pend = 0; m_perr = 0;
            m_free = k + 1 + H;
            cq.push_back(k + 1 + H);
        end else if (idle && r) begin
            for (int i = 0; i < NR; i++) m_sh[i] = m_ac[i];
            m_pend = 0;
        end else if (idle && wv) begin
            wacc = 1;
            err = (wa >= NR) || (m_ac[LK][0] && wa != LK);
            if (!err) begin m_sh[wa[4:0]] = wd; m_pend = 1; end
            wq.push_back('{k + 1, err});
        end else if (idle && rv) begin
            racc = 1;
            if (ra >= NR) d = '0;
            else if (rs)  d = m_ac[ra[4:0]];
            else          d = m_sh[ra[4:0]];
            rq.push_back('{k + 1, d, ra >= NR});
        end
    endtask

    task automatic idle_cycles(input int n);
        bit a, b;
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, '0, 0, a, b);
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues and model state.
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (mon_en) begin
                bit e;
                chk("busy", NR*RW'(busy), NR*RW'(cyc < m_free));
                chk("pending", NR*RW'(pending), NR*RW'(m_pend));
                if (!inject) begin
                    chk("config_bits", config_bits, pack_ac());
                    chk("parity_err", NR*RW'(parity_err), NR*RW'(m_perr));
                end
                e = (wq.size() > 0) && (wq[0].c == cyc);
                chk("wr_resp", NR*RW'(wr_resp), NR*RW'(e));
                if (e) begin
                    if (wr_resp) chk("wr_err", NR*RW'(wr_err), NR*RW'(wq[0].err));
                    void'(wq.pop_front());
                end
                e = (rq.size() > 0) && (rq[0].c == cyc);
                chk("rd_resp", NR*RW'(rd_resp), NR*RW'(e));
                if (e) begin
                    if (rd_resp) begin
                        chk("rd_data", NR*RW'(rd_data), NR*RW'(rq[0].d));
                        chk("rd_err", NR*RW'(rd_err), NR*RW'(rq[0].err));
                    end
                    void'(rq.pop_front());
                end
                e = (cq.size() > 0) && (cq[0] == cyc);
                chk("commit_done", NR*RW'(commit_done), NR*RW'(e));
                if (e) void'(cq.pop_front());
            end
        end
    end

    initial begin
        bit a, b, wv, rv, rs, c, r;
        logic [AW-1:0] wa, ra;
        logic [RW-1:0] wd;
        int n;
        for (int i = 0; i < NR; i++) begin
            m_sh[i] = DEF[i*RW +: RW];
            m_ac[i] = DEF[i*RW +: RW];
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_config_bits", config_bits, DEF);
        chk("rst_pending", NR*RW'(pending), '0);
        chk("rst_busy", NR*RW'(busy), '0);
        chk("rst_commit_done", NR*RW'(commit_done), '0);
        chk("rst_resp", NR*RW'({wr_resp, wr_err, rd_resp, rd_err}), '0);
        chk("rst_rd_data", NR*RW'(rd_data), '0);
        chk("rst_parity_err", NR*RW'(parity_err), '0);
        @(negedge clk);
        reset = 0;
        mon_en = 1;

        // Basic read, write, shadow/active read-back
        step(0, 0, 0, '0, '0, 1, 6'd3, 1, a, b);
        step(0, 0, 1, 6'd5, 8'hA5, 0, '0, 0, a, b);
        step(0, 0, 0, '0, '0, 1, 6'd5, 0, a, b);
        step(0, 0, 0, '0, '0, 1, 6'd5, 1, a, b);
        idle_cycles(2);

        // Commit, then a write held through the settle window
        step(1, 0, 0, '0, '0, 0, '0, 0, a, b);
        n = 0;
        do begin step(0, 0, 1, 6'd6, 8'h3C, 0, '0, 0, a, b); n++; end while (!a && n < 40);
        idle_cycles(1);

        // Coincident commit, write and read
        wv = 1; rv = 1; c = 1; n = 0;
        do begin
            step(c, 0, wv, 6'd7, 8'h11, rv, 6'd7, 0, a, b);
            c = 0;
            if (a) wv = 0;
            if (b) rv = 0;
            n++;
        end while ((wv || rv) && n < 60);
        idle_cycles(1);

        // Lock register behaviour
        step(0, 0, 1, 6'(LK), 8'h01, 0, '0, 0, a, b);
        step(1, 0, 0, '0, '0, 0, '0, 0, a, b);
        idle_cycles(H + 1);
        step(0, 0, 1, 6'd2, 8'h77, 0, '0, 0, a, b);
        step(0, 0, 0, '0, '0, 1, 6'd2, 0, a, b);
        step(0, 0, 1, 6'd40, 8'h55, 0, '0, 0, a, b);
        step(0, 0, 1, 6'(LK), 8'h00, 0, '0, 0, a, b);
        step(1, 0, 0, '0, '0, 0, '0, 0, a, b);
        idle_cycles(H + 1);
        step(0, 0, 1, 6'd9, 8'h99, 0, '0, 0, a, b);
        step(0, 0, 0, '0, '0, 0, '0, 0, a, b);
        step(0, 1, 0, '0, '0, 0, '0, 0, a, b);
        step(0, 0, 0, '0, '0, 1, 6'd9, 0, a, b);
        step(0, 0, 0, '0, '0, 1, 6'd45, 1, a, b);

        // Randomized traffic with requesters holding valid until accepted
        wv = 0; rv = 0; wa = '0; ra = '0; wd = '0; rs = 0;
        for (int it = 0; it < 1500; it++) begin
            if (!wv && ($urandom % 3 == 0)) begin
                wv = 1;
                wa = 6'($urandom_range(0, 39));
                wd = 8'($urandom);
                if (wa == LK && ($urandom % 4 != 0)) wd[0] = 1'b0;
            end
            if (!rv && ($urandom % 3 == 0)) begin
                rv = 1;
                ra = 6'($urandom_range(0, 39));
                rs = 1'($urandom);
            end
            c = ($urandom % 20 == 0);
            r = ($urandom % 25 == 0);
            step(c, r, wv, wa, wd, rv, ra, rs, a, b);
            if (a) wv = 0;
            if (b) rv = 0;
        end
        idle_cycles(H + 4);

`ifdef REGMAP_PARITY_EN
        // Flip one active bit; the scrubber restores the default and flags it
        inject = 1;
        @(negedge clk);
        force dut.r_active[7] = m_ac[7] ^ 8'h01;
        @(negedge clk);
        release dut.r_active[7];
        idle_cycles(2 * NR + 2);
        m_ac[7] = DEF[7*RW +: RW];
        m_perr = 1;
        inject = 0;
        idle_cycles(2);
        step(1, 0, 0, '0, '0, 0, '0, 0, a, b);
        idle_cycles(H + 2);
`endif

        chk("wq_drained", NR*RW'(wq.size()), '0);
        chk("rq_drained", NR*RW'(rq.size()), '0);
        chk("cq_drained", NR*RW'(cq.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
